// File: rtl/score_pkg.sv
// Shared constants, conversion state encoding and the double-dabble nibble
// correction used by the score display block.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam int GLYPH_W     = 10;
    localparam int GLYPH_H     = 14;
    localparam int SHEET_W     = 100;
    localparam int NUM_DIGITS  = 4;
    localparam int SCALE       = 2;
    localparam int COMMIT_LINE = 480;

    localparam int BIN_W  = 14;
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int ADDR_W = $clog2(SHEET_W * GLYPH_H);

    localparam logic [BIN_W-1:0] SCORE_MAX = BIN_W'(9999);

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the next shift, so pre-add 3 to carry into the next decimal digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one double-dabble
// iteration per cycle. Inputs above 9999 saturate on load.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

    conv_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bcd_adj;

    // Next-state logic: load on start, shift 14 times, then one DONE cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        bcd_adj = {dabble_adj(bcd_q[15:12]), dabble_adj(bcd_q[11:8]),
                   dabble_adj(bcd_q[7:4]),   dabble_adj(bcd_q[3:0])};
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = (bin_i > SCORE_MAX) ? SCORE_MAX : bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == ITER_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_digit_ctrl.sv
// Four-digit score overlay: buffers score requests, converts them to BCD,
// commits new digits only at the start of vertical blanking, and produces
// glyph-ROM addresses plus a 2-cycle delayed pixel-enable.
module score_digit_ctrl
    import score_pkg::*;
#(
    parameter int X0 = 16,
    parameter int Y0 = 16
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [BIN_W-1:0]  score,
    input  logic              score_valid,
    output logic [ADDR_W-1:0] rom_address,
    output logic              digit_on,
    output logic              busy
);

    localparam logic [9:0] X_LO     = 10'(X0);
    localparam logic [9:0] X_HI     = 10'(X0 + NUM_DIGITS * GLYPH_W * SCALE - 1);
    localparam logic [9:0] Y_LO     = 10'(Y0);
    localparam logic [9:0] Y_HI     = 10'(Y0 + GLYPH_H * SCALE - 1);
    localparam logic [9:0] COMMIT_Y = 10'(COMMIT_LINE);
    localparam logic [3:0] COL_LAST = 4'(GLYPH_W - 1);
    localparam logic       SUB_LAST = 1'(SCALE - 1);

    logic             conv_start, conv_busy, conv_done;
    logic [BIN_W-1:0] conv_value;
    logic [BCD_W-1:0] conv_bcd;

    logic             pend_valid_q, pend_valid_d;
    logic [BIN_W-1:0] pend_q, pend_d;
    logic [BCD_W-1:0] shadow_q, shadow_d;
    logic [BCD_W-1:0] disp_q, disp_d;

    logic             sub_x_q, sub_x_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic             on_pipe_q, on_pipe_d;
    logic             on_q;

    logic             at_start, in_field;
    logic             cur_sub;
    logic [3:0]       cur_col;
    logic [1:0]       cur_idx;
    logic [3:0]       glyph_row, digit_val;
    logic             digit_vis;
    logic [ADDR_W-1:0] row_base, digit_base;

    bin2bcd_seq u_bin2bcd (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .start_i (conv_start),
        .bin_i   (conv_value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Request arbitration: a fresh request beats the pending one; requests
    // arriving while busy overwrite the single pending slot.
    always_comb begin
        conv_start   = 1'b0;
        conv_value   = score;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (conv_busy) begin
            if (score_valid) begin
                pend_valid_d = 1'b1;
                pend_d       = score;
            end
        end else if (score_valid) begin
            conv_start   = 1'b1;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            conv_start   = 1'b1;
            conv_value   = pend_q;
            pend_valid_d = 1'b0;
        end
    end

    // Shadow capture on DONE; displayed digits move only at the commit pixel,
    // taking a same-cycle DONE result straight through.
    always_comb begin
        shadow_d = conv_done ? conv_bcd : shadow_q;
        disp_d   = disp_q;
        if ((DrawX == 10'd0) && (DrawY == COMMIT_Y)) begin
            disp_d = shadow_d;
        end
    end

    // Horizontal cell counters: the current pixel's position is zero at the
    // field's left edge, otherwise the value advanced on the previous pixel.
    always_comb begin
        at_start = (DrawX == X_LO);
        in_field = (DrawX >= X_LO) && (DrawX <= X_HI) && (DrawY >= Y_LO) && (DrawY <= Y_HI);
        cur_sub  = at_start ? 1'b0 : sub_x_q;
        cur_col  = at_start ? 4'd0 : col_q;
        cur_idx  = at_start ? 2'd0 : idx_q;
        sub_x_d  = cur_sub;
        col_d    = cur_col;
        idx_d    = cur_idx;
        if (in_field) begin
            if (cur_sub == SUB_LAST) begin
                sub_x_d = 1'b0;
                if (cur_col == COL_LAST) begin
                    col_d = 4'd0;
                    idx_d = cur_idx + 2'd1;
                end else begin
                    col_d = cur_col + 4'd1;
                end
            end else begin
                sub_x_d = cur_sub + 1'b1;
            end
        end
    end

    // Glyph lookup: digit select, leading-zero blanking and shift-add address.
    always_comb begin
        glyph_row = 4'((DrawY - Y_LO) >> 1);
        digit_val = disp_q[3:0];
        digit_vis = 1'b1;
        case (cur_idx)
            2'd0: begin
                digit_val = disp_q[15:12];
                digit_vis = (disp_q[15:12] != 4'd0);
            end
            2'd1: begin
                digit_val = disp_q[11:8];
                digit_vis = (disp_q[15:8] != 8'd0);
            end
            2'd2: begin
                digit_val = disp_q[7:4];
                digit_vis = (disp_q[15:4] != 12'd0);
            end
            default: begin
                digit_val = disp_q[3:0];
                digit_vis = 1'b1;
            end
        endcase
        row_base   = ADDR_W'({glyph_row, 6'b0}) + ADDR_W'({glyph_row, 5'b0})
                   + ADDR_W'({glyph_row, 2'b0});
        digit_base = ADDR_W'({digit_val, 3'b0}) + ADDR_W'({digit_val, 1'b0});
        addr_d     = row_base + digit_base + ADDR_W'(cur_col);
        on_pipe_d  = in_field & blank & digit_vis;
    end

    // All registers, synchronous active-low reset.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            sub_x_q      <= 1'b0;
            col_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            on_pipe_q    <= 1'b0;
            on_q         <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            sub_x_q      <= sub_x_d;
            col_q        <= col_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            on_pipe_q    <= on_pipe_d;
            on_q         <= on_pipe_q;
        end
    end

    assign rom_address = addr_q;
    assign digit_on    = on_q;
    assign busy        = conv_busy;

endmodule

// File: doc/score_digit_ctrl.md
SCORE_DIGIT_CTRL -- requirements
Module: score_digit_ctrl

Interface
REQ-001 SHALL have parameter X0, default 16, meaning the left pixel column of the score field.
REQ-002 SHALL have parameter Y0, default 16, meaning the top pixel row of the score field.
REQ-003 SHALL have port vga_clk, input, width 1: the single clock; all logic rises on this edge.
REQ-004 SHALL have port reset_n, input, width 1: reset, synchronous and active-low.
REQ-005 SHALL have ports DrawX and DrawY, input, 10 bits each: current pixel coordinates.
REQ-006 SHALL have port blank, input, width 1: 1 means the pixel is in the active display area.
REQ-007 SHALL have port score, input, 14 bits: binary score, sampled when score_valid is 1.
REQ-008 SHALL have port score_valid, input, width 1: single-cycle request to display a new score.
REQ-009 SHALL have port rom_address, output, 11 bits: address into the numbers glyph ROM.
REQ-010 SHALL have port digit_on, output, width 1: the ROM data read for this pixel belongs to a visible glyph.
REQ-011 SHALL have port busy, output, width 1: BCD conversion in progress.

Function
REQ-012 Glyph ROM layout SHALL be 100 px wide x 14 rows; digit d occupies columns d*10..d*10+9; address = row*100 + d*10 + col, computed by shift-add (row*64+row*32+row*4), with no multiplier or divider.
REQ-013 Score field SHALL be 4 digits at scale 2: each cell is 20x28 px; the field spans X0..X0+79 and Y0..Y0+27; digit 0 (thousands) is leftmost.
REQ-014 Horizontal position SHALL be tracked by counters (sub_x 0..1, glyph_col 0..9, digit_idx 0..3), cleared when DrawX==X0 and advanced once per pixel inside the field; glyph_row SHALL be (DrawY-Y0)>>1.
REQ-015 rom_address SHALL be registered, 1 cycle after DrawX/DrawY; digit_on SHALL be delayed 2 cycles in total so that it aligns with the ROM's 1-cycle read data.
REQ-016 digit_on SHALL be 0 outside the field, when blank==0, and for leading-zero digits; the ones digit SHALL always be shown.
REQ-017 Conversion FSM SHALL have states IDLE, SHIFT, DONE. On score_valid in IDLE: load the value, go to SHIFT, busy=1.
REQ-018 SHIFT SHALL perform 14 double-dabble iterations, one per cycle (add 3 to each nibble >=5, then shift), then go to DONE. DONE SHALL write the shadow BCD register, clear busy, and return to IDLE (16 cycles from score_valid to busy==0).
REQ-019 A score input greater than 9999 SHALL saturate to 9999 when loaded.
REQ-020 score_valid while busy SHALL store the value in a single-entry pending register, and a newer request SHALL overwrite it. IDLE SHALL start the pending conversion on the cycle after DONE.
REQ-021 Displayed digits SHALL copy from the shadow register only on the cycle DrawX==0 and DrawY==480 (vertical blanking), so a frame never tears. If DONE and the commit fall on the same cycle, the new shadow value SHALL be the one committed.

Reset
REQ-022 On reset_n==0 at a clock edge: FSM goes to IDLE; busy=0; pending is cleared; shadow and displayed digits are 0; rom_address=0; digit_on=0; all counters are 0.
REQ-023 A reset during SHIFT SHALL abort the conversion; the partial result SHALL never reach shadow.

Structure
REQ-024 A shared package score_pkg SHALL hold: the conversion state enum; the constants GLYPH_W=10, GLYPH_H=14, SHEET_W=100, NUM_DIGITS=4, SCALE=2, and the commit line 480.
REQ-025 The BCD converter SHALL be its own sub-module, bin2bcd_seq, with a start/busy/done handshake; address generation SHALL stay in score_digit_ctrl.

Verification
REQ-026 score=1234 pulse at reset release -> busy is high for 15 cycles; after the next commit line, the pixel (X0+20,Y0) produces rom_address=20 two cycles earlier, and digit_on=1 aligned with it.
REQ-027 score=7 -> digits 0..2 are blanked (digit_on=0 across X0..X0+59); the ones cell at (X0+61,Y0+3) gives address 1*100+70+0=170.
REQ-028 score=12000 -> displayed value 9999; the pixel (X0+79,Y0+27) gives address 13*100+99=1399.
REQ-029 score_valid with 5, then 6, then 8 on consecutive busy cycles -> final displayed value 8; exactly two conversions run.
REQ-030 Conversion finishes mid-frame -> the displayed digits stay unchanged for the rest of the frame and update at DrawY==480, DrawX==0.
REQ-031 reset_n low for 1 cycle during SHIFT -> busy=0 the next cycle; the displayed value is 0, shown as a single "0".
